// File: rtl/mc_exec_pkg.sv
// Shared definitions for the multi-cycle MIPS R-type execution core:
// FSM state encoding, opcode/funct constants, trap causes and instruction decode.
package mc_exec_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_ADDU,
    ALU_SUB,
    ALU_SUBU,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_ILL
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic CAUSE_OVF = 1'b0;
  localparam logic CAUSE_ILL = 1'b1;

  // Map an instruction word to an ALU operation; anything unsupported is ALU_ILL.
  function automatic alu_op_t decode_op(input logic [31:0] word);
    alu_op_t op;
    op = ALU_ILL;
    if (word[31:26] == OP_RTYPE) begin
      case (word[5:0])
        FN_ADD:  op = ALU_ADD;
        FN_ADDU: op = ALU_ADDU;
        FN_SUB:  op = ALU_SUB;
        FN_SUBU: op = ALU_SUBU;
        FN_AND:  op = ALU_AND;
        FN_OR:   op = ALU_OR;
        FN_XOR:  op = ALU_XOR;
        FN_NOR:  op = ALU_NOR;
        FN_SLT:  op = ALU_SLT;
        FN_SLTU: op = ALU_SLTU;
        default: op = ALU_ILL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mc_exec_alu.sv
// Combinational ALU for the execution core: wrapping DATA_W-bit result plus
// signed-overflow flag, which is only raised for the trapping add/sub forms.
module mc_exec_alu
  import mc_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t                  op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result,
  output logic                     ovf
);

  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Select the result; overflow means the sign of the wrapped result disagrees
  // with what the operand signs imply.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum;
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_ADDU: result = sum;
      ALU_SUB: begin
        result = diff;
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUBU: result = diff;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_exec_core.sv
// Multi-cycle MIPS R-type execution core: FETCH -> DECODE -> EXEC -> WB, one
// instruction in flight, overflow/illegal traps redirect the PC to TRAP_VEC.
// Optional debug register read port is enabled by defining MC_EXEC_CORE_DBG_EN.
module mc_exec_core
  import mc_exec_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              NREGS    = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] TRAP_VEC = 'h80
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [PC_W-1:0] pc_out,
  output logic            retire,
  output logic            trap,
  output logic            trap_cause
`ifdef MC_EXEC_CORE_DBG_EN
  ,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t                   state;
  state_t                   state_nxt;
  logic [31:0]              ir;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic signed [DATA_W-1:0] alu_out;
  logic signed [DATA_W-1:0] alu_res;
  logic                     ov_q;
  logic                     ill_q;
  logic                     alu_ovf;
  logic [DATA_W-1:0]        regs [NREGS];
  logic [IDX_W-1:0]         rs_idx;
  logic [IDX_W-1:0]         rt_idx;
  logic [IDX_W-1:0]         rd_idx;
  alu_op_t                  op;
  logic                     accept;
  logic                     wb_fault;
  logic                     wb_write;
  logic                     unused_ir;

  // Register indices are the low bits of the MIPS fields, so wider indices alias.
  assign rs_idx    = ir[21 +: IDX_W];
  assign rt_idx    = ir[16 +: IDX_W];
  assign rd_idx    = ir[11 +: IDX_W];
  assign op        = decode_op(ir);
  assign unused_ir = ^ir;

  assign accept   = instr_valid && instr_ready;
  assign wb_fault = ov_q || ill_q;
  assign wb_write = (state == ST_WB) && !wb_fault && (rd_idx != '0);

  mc_exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // State register; clr aborts whatever is in flight and returns to FETCH.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: wait in FETCH for a handshake, then walk the fixed sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (accept) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_FETCH;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // Outputs: handshake only in FETCH, completion pulses only in WB, all masked by clr.
  always_comb begin
    instr_ready = 1'b0;
    retire      = 1'b0;
    trap        = 1'b0;
    trap_cause  = CAUSE_OVF;
    if (!clr) begin
      case (state)
        ST_FETCH: instr_ready = 1'b1;
        ST_WB: begin
          retire     = !wb_fault;
          trap       = wb_fault;
          trap_cause = (wb_fault && ill_q) ? CAUSE_ILL : CAUSE_OVF;
        end
        default: ;
      endcase
    end
  end

  // Datapath: IR capture, operand read, ALU latch, and WB commit of PC/register.
  always_ff @(posedge clk) begin
    if (clr) begin
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      ov_q    <= 1'b0;
      ill_q   <= 1'b0;
      pc_out  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (accept) begin
        ir <= instr;
      end
      if (state == ST_DECODE) begin
        a_q <= (rs_idx == '0) ? '0 : regs[rs_idx];
        b_q <= (rt_idx == '0) ? '0 : regs[rt_idx];
      end
      if (state == ST_EXEC) begin
        alu_out <= alu_res;
        ov_q    <= alu_ovf;
        ill_q   <= (op == ALU_ILL);
      end
      if (state == ST_WB) begin
        pc_out <= wb_fault ? TRAP_VEC : pc_out + PC_W'(4);
        if (wb_write) begin
          regs[rd_idx] <= alu_out;
        end
      end
    end
  end

`ifdef MC_EXEC_CORE_DBG_EN
  logic [IDX_W-1:0] dbg_idx;
  logic             unused_dbg;

  assign dbg_idx    = dbg_raddr[IDX_W-1:0];
  assign unused_dbg = ^dbg_raddr;
  assign dbg_rdata  = (dbg_idx == '0) ? '0 : regs[dbg_idx];
`endif

endmodule

// File: tb/tb_mc_exec_core.sv
// Self-checking bench for mc_exec_core: a 32-bit/32-register instance and a
// 16-bit/8-register instance, table-driven instruction vectors with a
// scoreboard of expected completion events, plus idle and clr corner cases.
module tb_mc_exec_core;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam int K_RET = 0;
  localparam int K_OVF = 1;
  localparam int K_ILL = 2;

  typedef struct {
    logic [2:0]  flags;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] word;
    int          kind;
    int          rd;
    logic [63:0] val;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        v32, v16;
  logic [31:0] i32, i16;
  logic        rdy32, rdy16, ret32, ret16, trp32, trp16, cs32, cs16;
  logic [31:0] pc32, pc16;

  exp_t        sb0[$];
  exp_t        sb1[$];
  vec_t        vecs32[$];
  vec_t        vecs16[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] pc_exp [2];
  logic        pend [2];
  logic [31:0] pend_pc [2];

  always #5 clk = ~clk;

`ifdef MC_EXEC_CORE_DBG_EN
  logic [31:0] dbg32;
  logic [15:0] dbg16;
`endif

  mc_exec_core #(.DATA_W(32), .NREGS(32), .PC_W(32), .TRAP_VEC(32'h80)) dut32 (
    .clk(clk), .clr(clr), .instr_valid(v32), .instr_ready(rdy32), .instr(i32),
    .pc_out(pc32), .retire(ret32), .trap(trp32), .trap_cause(cs32)
`ifdef MC_EXEC_CORE_DBG_EN
    , .dbg_raddr(5'd0), .dbg_rdata(dbg32)
`endif
  );

  mc_exec_core #(.DATA_W(16), .NREGS(8), .PC_W(32), .TRAP_VEC(32'h80)) dut16 (
    .clk(clk), .clr(clr), .instr_valid(v16), .instr_ready(rdy16), .instr(i16),
    .pc_out(pc16), .retire(ret16), .trap(trp16), .trap_cause(cs16)
`ifdef MC_EXEC_CORE_DBG_EN
    , .dbg_raddr(5'd0), .dbg_rdata(dbg16)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rw(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0];
    t = rt[4:0];
    d = rd[4:0];
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction

  function automatic logic [63:0] reg_of(input int sel, input int idx);
    if (sel == 0) return 64'(dut32.regs[idx]);
    return 64'(dut16.regs[idx]);
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] word, input int kind,
                              input int rd, input logic [63:0] val);
    vec_t v;
    v.name = name;
    v.word = word;
    v.kind = kind;
    v.rd   = rd;
    v.val  = val;
    return v;
  endfunction

  task automatic drive(input int sel, input logic vld, input logic [31:0] word);
    if (sel == 0) begin
      v32 = vld;
      i32 = word;
    end else begin
      v16 = vld;
      i16 = word;
    end
  endtask

  // Issue one instruction, push its expected completion, check latency and re-ready.
  task automatic issue(input int sel, input logic [31:0] word, input int kind, input string name);
    exp_t e;
    int   n;
    int   k;
    logic rdy;
    logic pulse;
    @(negedge clk);
    drive(sel, 1'b1, word);
    e.flags = (kind == K_RET) ? 3'b100 : (kind == K_OVF) ? 3'b010 : 3'b011;
    e.pc    = (kind == K_RET) ? pc_exp[sel] + 32'd4 : 32'h80;
    pc_exp[sel] = e.pc;
    if (sel == 0) sb0.push_back(e);
    else sb1.push_back(e);
    n = 0;
    #1 rdy = (sel == 0) ? rdy32 : rdy16;
    while (!rdy && n < 20) begin
      @(negedge clk);
      #1 rdy = (sel == 0) ? rdy32 : rdy16;
      n++;
    end
    if (!rdy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_accept: instr_ready never seen within 20 cycles", name);
      drive(sel, 1'b0, 32'h0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, $urandom);
    k = 1;
    #2 pulse = (sel == 0) ? (ret32 | trp32) : (ret16 | trp16);
    while (!pulse && k < 10) begin
      @(negedge clk);
      #2 pulse = (sel == 0) ? (ret32 | trp32) : (ret16 | trp16);
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'd3);
    @(negedge clk);
    #2 check({name, "_ready_n4"}, 64'((sel == 0) ? rdy32 : rdy16), 64'd1);
  endtask

  // Pop the scoreboard on each completion pulse and verify the PC one cycle later.
  task automatic mon(input int d);
    logic        r, t, c;
    logic [31:0] p;
    exp_t        e;
    r = (d == 0) ? ret32 : ret16;
    t = (d == 0) ? trp32 : trp16;
    c = (d == 0) ? cs32 : cs16;
    p = (d == 0) ? pc32 : pc16;
    if (pend[d]) begin
      check($sformatf("pc_after_wb_dut%0d", d), 64'(p), 64'(pend_pc[d]));
      pend[d] = 1'b0;
    end
    if (r || t) begin
      check($sformatf("retire_trap_excl_dut%0d", d), 64'(r & t), 64'd0);
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse_dut%0d: retire=%0b trap=%0b with nothing expected", d, r, t);
      end else begin
        if (d == 0) e = sb0.pop_front();
        else e = sb1.pop_front();
        check($sformatf("flags_dut%0d", d), 64'({r, t, t & c}), 64'(e.flags));
        pend[d]    = 1'b1;
        pend_pc[d] = e.pc;
      end
    end
  endtask

  // Completion monitor, sampling 2 time units after each falling edge.
  always begin
    @(negedge clk);
    #2;
    mon(0);
    mon(1);
  end

  initial begin
    clr        = 1'b1;
    v32        = 1'b0;
    v16        = 1'b0;
    i32        = 32'h0;
    i16        = 32'h0;
    pc_exp[0]  = 32'h0;
    pc_exp[1]  = 32'h0;
    pend[0]    = 1'b0;
    pend[1]    = 1'b0;

    vecs32.push_back(mk("nor_m1",     rw(0, 0, 10, F_NOR),  K_RET, 10, 64'hFFFF_FFFF));
    vecs32.push_back(mk("subu_one",   rw(0, 10, 11, F_SUBU), K_RET, 11, 64'd1));
    vecs32.push_back(mk("addu_two",   rw(11, 11, 12, F_ADDU), K_RET, 12, 64'd2));
    vecs32.push_back(mk("addu_four",  rw(12, 12, 13, F_ADDU), K_RET, 13, 64'd4));
    vecs32.push_back(mk("r1_five",    rw(13, 11, 1, F_ADDU), K_RET, 1, 64'd5));
    vecs32.push_back(mk("addu_six",   rw(13, 12, 14, F_ADDU), K_RET, 14, 64'd6));
    vecs32.push_back(mk("r2_seven",   rw(14, 11, 2, F_ADDU), K_RET, 2, 64'd7));
    vecs32.push_back(mk("add_r3_12",  rw(1, 2, 3, F_ADD),   K_RET, 3, 64'd12));
    vecs32.push_back(mk("slt_m1_1",   rw(10, 11, 4, F_SLT), K_RET, 4, 64'd1));
    vecs32.push_back(mk("sltu_1_m1",  rw(11, 10, 5, F_SLTU), K_RET, 5, 64'd1));
    vecs32.push_back(mk("sltu_m1_1",  rw(10, 11, 5, F_SLTU), K_RET, 5, 64'd0));
    vecs32.push_back(mk("and",        rw(1, 2, 6, F_AND),   K_RET, 6, 64'd5));
    vecs32.push_back(mk("or",         rw(1, 2, 7, F_OR),    K_RET, 7, 64'd7));
    vecs32.push_back(mk("xor",        rw(1, 2, 8, F_XOR),   K_RET, 8, 64'd2));
    vecs32.push_back(mk("nor",        rw(1, 2, 9, F_NOR),   K_RET, 9, 64'hFFFF_FFF8));
    vecs32.push_back(mk("sub_neg",    rw(1, 2, 15, F_SUB),  K_RET, 15, 64'hFFFF_FFFE));
    vecs32.push_back(mk("subu_pos",   rw(2, 1, 16, F_SUBU), K_RET, 16, 64'd2));
    vecs32.push_back(mk("write_r0",   rw(1, 2, 0, F_ADDU),  K_RET, 0, 64'd0));
    vecs32.push_back(mk("read_r0",    rw(0, 1, 26, F_ADDU), K_RET, 26, 64'd5));
    vecs32.push_back(mk("lw_illegal", {6'h23, 5'd1, 5'd3, 16'h1804}, K_ILL, 3, 64'd12));
    vecs32.push_back(mk("jr_illegal", rw(1, 0, 3, 6'h08),   K_ILL, 3, 64'd12));
    vecs32.push_back(mk("after_trap", rw(1, 2, 20, F_ADDU), K_RET, 20, 64'd12));
    vecs32.push_back(mk("r17_one",    rw(11, 0, 17, F_ADDU), K_RET, 17, 64'd1));
    for (int k = 1; k < 32; k++)
      vecs32.push_back(mk($sformatf("dbl32_%0d", k), rw(17, 17, 17, F_ADDU), K_RET, 17, 64'(32'h1 << k)));
    vecs32.push_back(mk("nor_7fff",   rw(17, 0, 18, F_NOR), K_RET, 18, 64'h7FFF_FFFF));
    vecs32.push_back(mk("add_ovf",    rw(18, 11, 19, F_ADD), K_OVF, 19, 64'd0));
    vecs32.push_back(mk("addu_wrap",  rw(18, 11, 19, F_ADDU), K_RET, 19, 64'h8000_0000));
    vecs32.push_back(mk("sub_ovf",    rw(17, 11, 21, F_SUB), K_OVF, 21, 64'd0));
    vecs32.push_back(mk("subu_wrap",  rw(17, 11, 21, F_SUBU), K_RET, 21, 64'h7FFF_FFFF));
    vecs32.push_back(mk("add_neg_ovf", rw(17, 17, 22, F_ADD), K_OVF, 22, 64'd0));
    vecs32.push_back(mk("add_neg_ok", rw(10, 10, 23, F_ADD), K_RET, 23, 64'hFFFF_FFFE));

    vecs16.push_back(mk("n16_rd9_r1",  rw(0, 0, 9, F_NOR),   K_RET, 1, 64'hFFFF));
    vecs16.push_back(mk("n16_subu1",   rw(0, 1, 2, F_SUBU),  K_RET, 2, 64'd1));
    vecs16.push_back(mk("n16_rs17",    rw(17, 0, 7, F_ADDU), K_RET, 7, 64'hFFFF));
    vecs16.push_back(mk("n16_r3_one",  rw(2, 0, 3, F_ADDU),  K_RET, 3, 64'd1));
    for (int k = 1; k < 16; k++)
      vecs16.push_back(mk($sformatf("dbl16_%0d", k), rw(3, 3, 3, F_ADDU), K_RET, 3, 64'(16'h1 << k)));
    vecs16.push_back(mk("n16_sub_ovf", rw(3, 2, 4, F_SUB),   K_OVF, 4, 64'd0));
    vecs16.push_back(mk("n16_nor7fff", rw(3, 0, 5, F_NOR),   K_RET, 5, 64'h7FFF));
    vecs16.push_back(mk("n16_add_ovf", rw(5, 2, 6, F_ADD),   K_OVF, 6, 64'd0));
    vecs16.push_back(mk("n16_addu",    rw(5, 2, 6, F_ADDU),  K_RET, 6, 64'h8000));
    vecs16.push_back(mk("n16_slt",     rw(1, 2, 4, F_SLT),   K_RET, 4, 64'd1));

    // Reset: second clr cycle has the FSM in FETCH, yet ready must stay low.
    repeat (2) @(negedge clk);
    #2;
    check("rst_ready32", 64'(rdy32), 64'd0);
    check("rst_ready16", 64'(rdy16), 64'd0);
    check("rst_pc32", 64'(pc32), 64'd0);
    check("rst_pc16", 64'(pc16), 64'd0);
    check("rst_pulses", 64'({ret32, trp32, cs32, ret16, trp16, cs16}), 64'd0);
    clr = 1'b0;
    @(negedge clk);
    #2;
    check("ready_after_clr32", 64'(rdy32), 64'd1);
    check("ready_after_clr16", 64'(rdy16), 64'd1);

    foreach (vecs32[j]) begin
      issue(0, vecs32[j].word, vecs32[j].kind, vecs32[j].name);
      check({vecs32[j].name, "_reg"}, reg_of(0, vecs32[j].rd), vecs32[j].val);
    end

    // Idle: no valid for 5 cycles, FSM must sit in FETCH with a stable PC.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #2;
      check("idle_ready", 64'(rdy32), 64'd1);
      check("idle_pc", 64'(pc32), 64'(pc_exp[0]));
    end

    // clr while the instruction is in EXEC: aborted, PC and registers cleared.
    @(negedge clk);
    drive(0, 1'b1, rw(1, 2, 27, F_ADDU));
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    #2 check("clr_exec_ready", 64'(rdy32), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    pc_exp[0] = 32'h0;
    pc_exp[1] = 32'h0;
    #2;
    check("clr_exec_pc", 64'(pc32), 64'd0);
    check("clr_exec_rd", reg_of(0, 27), 64'd0);
    check("clr_exec_r1", reg_of(0, 1), 64'd0);
    check("clr_exec_ready_after", 64'(rdy32), 64'd1);

    issue(0, rw(0, 0, 10, F_NOR), K_RET, "post_clr_nor");
    check("post_clr_nor_reg", reg_of(0, 10), 64'hFFFF_FFFF);

    // clr during WB: no pulse and no register write.
    @(negedge clk);
    drive(0, 1'b1, rw(10, 0, 28, F_ADDU));
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    #2 check("clr_wb_no_pulse", 64'({ret32, trp32}), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    pc_exp[0] = 32'h0;
    pc_exp[1] = 32'h0;
    #2;
    check("clr_wb_rd", reg_of(0, 28), 64'd0);
    check("clr_wb_pc", 64'(pc32), 64'd0);

    foreach (vecs16[j]) begin
      issue(1, vecs16[j].word, vecs16[j].kind, vecs16[j].name);
      check({vecs16[j].name, "_reg"}, reg_of(1, vecs16[j].rd), vecs16[j].val);
    end
    check("n16_pc_end", 64'(pc16), 64'(pc_exp[1]));

    repeat (3) @(negedge clk);
    #3;
    check("sb32_drained", 64'(sb0.size()), 64'd0);
    check("sb16_drained", 64'(sb1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
